// File: rtl/fb_pkg.sv
// Shared widths, FSM encoding and MIG payload types for the framebuffer line writer.
package fb_pkg;

  localparam int unsigned FB_LINE_STRIDE_BYTES = 2048;
  localparam int unsigned MIG_BL_W             = 6;
  localparam int unsigned MIG_ADDR_W           = 30;
  localparam int unsigned LINE_ADDR_W          = 16;
  localparam int unsigned PIX_W                = 16;
  localparam int unsigned WORD_W               = 32;
  localparam int unsigned MASK_W               = 4;
  localparam int unsigned BE_W                 = 2;
  localparam int unsigned WORD_IDX_W           = $clog2(FB_LINE_STRIDE_BYTES) - 2;
  localparam int unsigned WORD_CNT_W           = 11;
  localparam int unsigned BURST_CNT_W          = 7;
  localparam int unsigned ST_W                 = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_FILL = 2'd1;
  localparam logic [ST_W-1:0] ST_CMD  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [MIG_BL_W-1:0]   bl;
    logic [MIG_ADDR_W-1:0] byte_addr;
  } mig_cmd_t;

  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [WORD_W-1:0] data;
  } mig_wr_t;

  // Byte address of a 32-bit word inside a line; the line stride is fixed, never accumulated.
  function automatic logic [MIG_ADDR_W-1:0] line_byte_addr(
    input logic [LINE_ADDR_W-1:0] line,
    input logic [WORD_IDX_W-1:0]  word
  );
    return MIG_ADDR_W'({line, word, 2'b00});
  endfunction

endpackage

// File: rtl/fb_pix_pack16to32.sv
// Packs accepted 16-bit pixels into {odd, even} 32-bit MIG write words.
// With FB_WRITE_MASK_EN defined, per-pixel byte enables become the registered write mask.
module fb_pix_pack16to32
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
`ifdef FB_WRITE_MASK_EN
  input  logic [BE_W-1:0]  pix_be,
`endif
  input  logic             wr_full,
  output logic             pix_ready_c,
  output logic             word_done_c,
  output logic             wr_en,
  output mig_wr_t          wr
);

  logic             phase;
  logic [PIX_W-1:0] lo_q;
  logic             accept;
  logic [MASK_W-1:0] mask_next;

  // The odd pixel is only refused when its word could not be pushed next cycle.
  assign pix_ready_c = en && !(phase && wr_full);
  assign accept      = pix_valid && pix_ready_c;
  assign word_done_c = accept && phase;

`ifdef FB_WRITE_MASK_EN
  logic [BE_W-1:0] be_lo_q;

  assign mask_next = ~{pix_be, be_lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      be_lo_q <= '0;
    end else if (accept && !phase) begin
      be_lo_q <= pix_be;
    end
  end
`else
  assign mask_next = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      lo_q  <= '0;
      wr_en <= 1'b0;
      wr    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (clear) begin
        phase <= 1'b0;
      end else if (accept) begin
        if (!phase) begin
          lo_q  <= pix_data;
          phase <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr.data <= {pix_data, lo_q};
          wr.mask <= mask_next;
          phase   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fb_line_writer.sv
// Writes one display line of RGB565 pixels into DDR3 over MIG port c3_p2 in fixed bursts.
// Optional per-pixel byte masking is enabled by defining FB_WRITE_MASK_EN.
module fb_line_writer
  import fb_pkg::*;
#(
  parameter int unsigned BURST_WORDS = 16,
  parameter int unsigned LINE_PIXELS = 1024
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   line_req,
  input  logic [LINE_ADDR_W-1:0] line_addr,
  output logic                   line_ack,
  output logic                   busy,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
`ifdef FB_WRITE_MASK_EN
  input  logic [BE_W-1:0]        pix_be,
`endif
  output logic                   pix_ready,
  output logic                   c3_p2_cmd_en,
  input  logic                   c3_p2_cmd_full,
  output logic                   c3_p2_cmd_rw,
  output logic [MIG_BL_W-1:0]    c3_p2_cmd_bl,
  output logic [MIG_ADDR_W-1:0]  c3_p2_cmd_byte_addr,
  output logic                   c3_p2_wr_en,
  output logic [WORD_W-1:0]      c3_p2_wr_data,
  output logic [MASK_W-1:0]      c3_p2_wr_mask,
  input  logic                   c3_p2_wr_full
);

  localparam int unsigned LINE_WORDS = LINE_PIXELS / 2;

  if (BURST_WORDS < 1 || BURST_WORDS > 64 || LINE_PIXELS > 1024 || (LINE_PIXELS % 2) != 0 ||
      (LINE_WORDS % BURST_WORDS) != 0) begin : g_bad_param
    $error("fb_line_writer: unsupported BURST_WORDS/LINE_PIXELS combination");
  end

  logic [ST_W-1:0]        state, state_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_CNT_W-1:0]  word_cnt, word_cnt_d;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_d;
  mig_cmd_t               cmd_q, cmd_d;
  logic                   cmd_en_d;
  logic                   line_ack_d;
  logic                   clear;
  logic                   word_done_c;
  logic                   fill_en;
  logic [WORD_IDX_W-1:0]  base;
  mig_wr_t                wr;

  assign fill_en = (state == ST_FILL);
  // word_cnt already counts the burst being committed; only the low index bits form the address.
  assign base    = word_cnt[WORD_IDX_W-1:0] - WORD_IDX_W'(BURST_WORDS);

  fb_pix_pack16to32 u_pack (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .en          (fill_en),
    .clear       (clear),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
`ifdef FB_WRITE_MASK_EN
    .pix_be      (pix_be),
`endif
    .wr_full     (c3_p2_wr_full),
    .pix_ready_c (pix_ready),
    .word_done_c (word_done_c),
    .wr_en       (c3_p2_wr_en),
    .wr          (wr)
  );

  assign c3_p2_wr_data       = wr.data;
  assign c3_p2_wr_mask       = wr.mask;
  assign c3_p2_cmd_rw        = 1'b0;
  assign c3_p2_cmd_bl        = cmd_q.bl;
  assign c3_p2_cmd_byte_addr = cmd_q.byte_addr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      word_cnt     <= '0;
      burst_cnt    <= '0;
      cmd_q        <= '0;
      c3_p2_cmd_en <= 1'b0;
      line_ack     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      addr_q       <= addr_d;
      word_cnt     <= word_cnt_d;
      burst_cnt    <= burst_cnt_d;
      cmd_q        <= cmd_d;
      c3_p2_cmd_en <= cmd_en_d;
      line_ack     <= line_ack_d;
      busy         <= (state_d != ST_IDLE);
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt;
    burst_cnt_d = burst_cnt;
    cmd_d       = cmd_q;
    cmd_en_d    = 1'b0;
    line_ack_d  = line_ack;
    clear       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (line_req && !line_ack) begin
          state_d     = ST_FILL;
          addr_d      = line_addr;
          word_cnt_d  = '0;
          burst_cnt_d = '0;
          clear       = 1'b1;
        end
      end
      ST_FILL: begin
        if (word_done_c) begin
          word_cnt_d  = word_cnt + WORD_CNT_W'(1);
          burst_cnt_d = burst_cnt + BURST_CNT_W'(1);
          if (burst_cnt + BURST_CNT_W'(1) == BURST_CNT_W'(BURST_WORDS)) begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        // The last data word is pushed while in CMD, so the command always trails its data.
        if (!c3_p2_cmd_full) begin
          cmd_en_d        = 1'b1;
          cmd_d.bl        = MIG_BL_W'(BURST_WORDS - 1);
          cmd_d.byte_addr = line_byte_addr(addr_q, base);
          burst_cnt_d     = '0;
          if (word_cnt == WORD_CNT_W'(LINE_WORDS)) begin
            state_d    = ST_DONE;
            line_ack_d = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_DONE: begin
        if (!line_req) begin
          line_ack_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/fb_line_writer.md
Name: fb_line_writer

Overview:
- Writes one display line of 16-bit pixels into DDR3 through the MIG user write port (c3_p2); it is the write-side counterpart of the VGA line reader on c3_p1.
- A producer (blitter/CPU bridge) streams pixels with a valid/ready handshake. The block packs pixel pairs into 32-bit words, fills the MIG write FIFO and issues burst write commands.
- Line addressing matches the reader: byte address = {line_addr, word_idx[8:0], 2'b00}.
- A req/ack four-phase handshake frames each line.

Parameters:
- BURST_WORDS, 16, 32-bit words per write command (1..64; must divide LINE_PIXELS/2)
- LINE_PIXELS, 1024, pixels per line (even, at most 1024)

Ports:
- sys_clk  in  1  system clock (MIG user clock domain)
- sys_rst_n  in  1  asynchronous active-low reset
- line_req  in  1  level; request to write one line; held until line_ack=1
- line_addr  in  16  line index; sampled on the IDLE->FILL transition
- line_ack  out  1  high from line completion until line_req falls
- busy  out  1  high in any state other than IDLE
- pix_valid  in  1  pixel valid
- pix_data  in  16  pixel RGB565
- pix_ready  out  1  pixel accepted when pix_valid&&pix_ready
- c3_p2_cmd_en  out  1  command strobe
- c3_p2_cmd_full  in  1  MIG command FIFO full
- c3_p2_cmd_rw  out  1  always 0 (write)
- c3_p2_cmd_bl  out  6  burst length minus 1
- c3_p2_cmd_byte_addr  out  30  byte address
- c3_p2_wr_en  out  1  write-data strobe
- c3_p2_wr_data  out  32  {odd pixel, even pixel}
- c3_p2_wr_mask  out  4  byte mask, 1 = do not write
- c3_p2_wr_full  in  1  MIG write FIFO full

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous, active-low (sys_rst_n).
- Reset values: every output is 0. State = IDLE, word_cnt = 0, burst_cnt = 0, phase = 0.
- State IDLE:
  - line_req=1 && line_ack=0 -> FILL.
  - On that transition, latch line_addr into addr_q and clear word_cnt (11b), burst_cnt (7b) and phase.
- State FILL:
  - pix_ready = !(phase==1 && c3_p2_wr_full).
  - Accepted pixel with phase=0: store it in lo_q, set phase=1. No write that cycle.
  - Accepted pixel with phase=1: next cycle wr_en=1, wr_data={pix_data, lo_q}, wr_mask=0. Then phase=0, word_cnt++, burst_cnt++.
  - Latency: pixel accept to wr_en is 1 cycle. Throughput is 1 pixel/cycle.
  - When burst_cnt reaches BURST_WORDS (counted on the cycle that word is written) -> CMD.
- State CMD:
  - Wait while cmd_full=1.
  - Otherwise pulse cmd_en for exactly 1 cycle with bl=BURST_WORDS-1 and byte_addr = {3'b0, addr_q, base[8:0], 2'b00}, where base = word_cnt-BURST_WORDS.
  - Then clear burst_cnt. If word_cnt==LINE_PIXELS/2 -> DONE, else -> FILL.
  - Data is always in the FIFO before its command is issued, as MIG requires.
- State DONE:
  - line_ack=1; pix_ready=0.
  - When line_req=0: line_ack<=0 -> IDLE.
- Pixel flow control: pix_ready=0 in IDLE, CMD and DONE. Pixels offered outside FILL are held off, never dropped.
- wr_full asserted at the instant a word completes: the pixel is not accepted, and the pair is written on the first cycle with wr_full=0.
- Address wrap: word_cnt[8:0] addresses 512 words per line. addr_q is not incremented; the line stride is fixed at 2 KiB.
- Simultaneous line_req drop during FILL is ignored; the line always completes. A new req while line_ack=1 is not accepted until the ack falls.
- Reset mid-line: all state clears immediately and the partial burst is abandoned. The system resets MIG together with this block, so no partial data remains in the MIG FIFO.

Optional Feature:
- Macro: FB_WRITE_MASK_EN.
- Defined: adds input pix_be[1:0] (1 = write byte). The mask bits are latched per pixel. wr_mask = ~{be_odd, be_even} is registered alongside wr_data, allowing transparent/partial-pixel writes.
- Undefined: no pix_be port; wr_mask is constant 4'b0000.

Decomposition:
- Package fb_pkg:
  - FB_LINE_STRIDE_BYTES=2048
  - MIG_BL_W=6
  - MIG_ADDR_W=30
  - state encoding IDLE=0, FILL=1, CMD=2, DONE=3
- One sub-module, fb_pix_pack16to32: phase/lo_q pair packer with ready back-pressure (plus mask under the macro). The FSM and counters stay in the top module.

Test Plan:
- Full line, no back-pressure: line_addr=16'h0005, 1024 pixels of value n -> 32 cmds, addrs 0x2800,0x2840,...,0x2FC0, bl=15. First word=0x0001_0000. line_ack rises after the last cmd.
- cmd_full held 10 cycles at the first CMD -> cmd_en is delayed 10 cycles, no pixel accepted meanwhile, and addresses are unchanged.
- wr_full pulsed while phase=1 -> pix_ready=0 that cycle, the pair is written once with no duplicates, and total wr_en count stays 512.
- Handshake: hold line_req=1 after ack for 5 cycles -> line_ack stays 1 and busy=1 with no new FILL. Drop req -> ack=0 next cycle, IDLE.
- Reset asserted after 100 pixels -> all outputs 0 asynchronously. A new line after release starts at word 0 with freshly sampled line_addr.
- FB_WRITE_MASK_EN: pix_be=2'b01 for odd pixels and 2'b11 for even pixels -> wr_mask=4'b1000 on every word.
